// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the ID/EX hazard and stall control.
package hazard_stall_unit_pkg;

  // Register-ID width (16 architectural registers, r0 hardwired zero)
  localparam int unsigned PIPE_REG_W = 4;

  // Default EX occupancy, in cycles, of the multi-cycle units
  localparam int unsigned DEF_MUL_CYCLES = 3;
  localparam int unsigned DEF_DIV_CYCLES = 8;

  // EX write class: anything other than RW_NONE counts as a register write
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_ALU  = 2'b01;
  localparam logic [1:0] RW_MEM  = 2'b10;

  // Stall controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } hsu_state_e;

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  // Count enabled cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, multi-cycle mul/div occupancy and branch flush control
// for the ID/EX boundary, with a saturating stall-cycle counter.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned REG_W      = PIPE_REG_W,
  parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] registerOP1ID,
  input  logic [REG_W-1:0] registerOP2ID,
  input  logic             useOP1ID,
  input  logic             useOP2ID,
  input  logic [REG_W-1:0] registerOP1EX,
  input  logic             memReadEX,
  input  logic [1:0]       regWriteEX,
  input  logic             mulDivStartEX,
  input  logic             isDivEX,
  input  logic             branchTakenEX,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexWrite,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             exmemFlush,
  output logic             mulDivBusy,
  output logic             mulDivDone,
  output logic [CNT_W-1:0] stallCount
);

  localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  // Counter holds at most MAX_CYCLES-2, which always fits in clog2(MAX_CYCLES) bits
  localparam int unsigned OCC_W = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [OCC_W-1:0] MUL_LOAD = OCC_W'(MUL_CYCLES - 2);
  localparam logic [OCC_W-1:0] DIV_LOAD = OCC_W'(DIV_CYCLES - 2);

  hsu_state_e       state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OCC_W-1:0] occ_load;
  logic             load_use;

  // Load in EX feeding a source the ID instruction actually reads; r0 never hazards
  always_comb begin
    load_use = memReadEX && (regWriteEX != RW_NONE) && (registerOP1EX != '0) &&
               ((useOP1ID && (registerOP1ID == registerOP1EX)) ||
                (useOP2ID && (registerOP2ID == registerOP1EX)));
  end

  // Next-state logic and zero-latency control outputs
  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    exmemFlush = 1'b0;
    mulDivBusy = 1'b0;
    mulDivDone = 1'b0;
    state_d    = state_q;
    occ_d      = occ_q;
    occ_load   = isDivEX ? DIV_LOAD : MUL_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (branchTakenEX) begin
          ifidFlush = 1'b1;
          idexFlush = 1'b1;
        end else if (mulDivStartEX) begin
          mulDivBusy = 1'b1;
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          idexWrite  = 1'b0;
          exmemFlush = 1'b1;
          occ_d      = occ_load;
          state_d    = (occ_load != '0) ? ST_BUSY : ST_DONE;
        end else if (load_use) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          idexFlush = 1'b1;
        end
      end
      ST_BUSY: begin
        mulDivBusy = 1'b1;
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexWrite  = 1'b0;
        exmemFlush = 1'b1;
        occ_d      = occ_q - OCC_W'(1);
        if (occ_q == OCC_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        mulDivDone = 1'b1;
        state_d    = ST_IDLE;
        if (load_use) begin
          pcWrite   = 1'b0;
          ifidWrite = 1'b0;
          idexFlush = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs track reset immediately, independent of the ID/EX inputs
    if (rst) begin
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      idexWrite  = 1'b1;
      ifidFlush  = 1'b0;
      idexFlush  = 1'b0;
      exmemFlush = 1'b0;
      mulDivBusy = 1'b0;
      mulDivDone = 1'b0;
    end
  end

  // State and occupancy counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (~pcWrite),
    .count_o (stallCount)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit (MUL=3, DIV=8, CNT_W=4).
module tb_hazard_stall_unit;

  localparam int unsigned CW = 4;

  // Expected control vectors: {pcW, ifidW, idexW, ifidF, idexF, exmemF, busy, done}
  localparam logic [7:0] V_NORM = 8'b1110_0000;
  localparam logic [7:0] V_LU   = 8'b0010_1000;
  localparam logic [7:0] V_BUSY = 8'b0000_0110;
  localparam logic [7:0] V_DONE = 8'b1110_0001;
  localparam logic [7:0] V_DLU  = 8'b0010_1001;
  localparam logic [7:0] V_BR   = 8'b1111_1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    registerOP1ID = '0, registerOP2ID = '0, registerOP1EX = '0;
  logic          useOP1ID = 1'b0, useOP2ID = 1'b0, memReadEX = 1'b0;
  logic [1:0]    regWriteEX = '0;
  logic          mulDivStartEX = 1'b0, isDivEX = 1'b0, branchTakenEX = 1'b0;
  logic          pcWrite, ifidWrite, idexWrite, ifidFlush, idexFlush, exmemFlush;
  logic          mulDivBusy, mulDivDone;
  logic [CW-1:0] stallCount;

  typedef struct {
    string         name;
    logic [7:0]    ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] model_cnt = '0;

  hazard_stall_unit #(
    .REG_W      (4),
    .MUL_CYCLES (3),
    .DIV_CYCLES (8),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .registerOP1ID (registerOP1ID),
    .registerOP2ID (registerOP2ID),
    .useOP1ID      (useOP1ID),
    .useOP2ID      (useOP2ID),
    .registerOP1EX (registerOP1EX),
    .memReadEX     (memReadEX),
    .regWriteEX    (regWriteEX),
    .mulDivStartEX (mulDivStartEX),
    .isDivEX       (isDivEX),
    .branchTakenEX (branchTakenEX),
    .pcWrite       (pcWrite),
    .ifidWrite     (ifidWrite),
    .idexWrite     (idexWrite),
    .ifidFlush     (ifidFlush),
    .idexFlush     (idexFlush),
    .exmemFlush    (exmemFlush),
    .mulDivBusy    (mulDivBusy),
    .mulDivDone    (mulDivDone),
    .stallCount    (stallCount)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge and queue its expected response
  task automatic vec(input string nm, input logic [3:0] o1id, input logic [3:0] o2id,
                     input logic u1, input logic u2, input logic [3:0] o1ex,
                     input logic mr, input logic [1:0] rw, input logic st,
                     input logic dv, input logic br, input logic r,
                     input logic [7:0] ectl);
    exp_t e;
    @(posedge clk);
    #1;
    registerOP1ID = o1id; registerOP2ID = o2id;
    useOP1ID = u1; useOP2ID = u2; registerOP1EX = o1ex;
    memReadEX = mr; regWriteEX = rw;
    mulDivStartEX = st; isDivEX = dv; branchTakenEX = br;
    rst = r;
    if (r) model_cnt = '0;
    e.name = nm;
    e.ctl  = ectl;
    e.cnt  = model_cnt;
    sb.push_back(e);
    if (!r && !ectl[7] && (model_cnt != '1)) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic idle(input string nm, input logic [7:0] ectl);
    vec(nm, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ectl);
  endtask

  // Monitor: compare the presented outputs mid-cycle against the oldest expectation
  initial begin
    exp_t        e;
    logic [7:0]  act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pcWrite, ifidWrite, idexWrite, ifidFlush, idexFlush, exmemFlush,
               mulDivBusy, mulDivDone};
        checks++;
        if (act !== e.ctl) begin
          failures++;
          $display("FAIL %s ctl actual=%b required=%b", e.name, act, e.ctl);
        end
        checks++;
        if (stallCount !== e.cnt) begin
          failures++;
          $display("FAIL %s stallCount actual=%0d required=%0d", e.name, stallCount, e.cnt);
        end
      end
    end
  end

  initial begin
    int unsigned guard;

    // Reset with a load-use pattern present: outputs stay at reset values
    vec("reset", 4'd0, 4'd5, 1'b0, 1'b1, 4'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, V_NORM);
    idle("idle0", V_NORM);

    // Load-use on OP2, then r0 and non-hazard variants
    vec("lu_op2", 4'd0, 4'd5, 1'b0, 1'b1, 4'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, V_LU);
    idle("after_lu", V_NORM);
    vec("lu_r0", 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, V_NORM);
    vec("lu_op1_rw11", 4'd7, 4'd2, 1'b1, 1'b0, 4'd7, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, V_LU);
    vec("nouse", 4'd7, 4'd7, 1'b0, 1'b0, 4'd7, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, V_NORM);
    vec("rw00", 4'd7, 4'd2, 1'b1, 1'b0, 4'd7, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, V_NORM);
    vec("noload", 4'd7, 4'd2, 1'b1, 1'b0, 4'd7, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, V_NORM);

    // Multiply: busy two cycles, done on the third
    vec("mul_start", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, V_BUSY);
    idle("mul_busy", V_BUSY);
    idle("mul_done", V_DONE);
    idle("mul_after", V_NORM);

    // Divide: busy seven cycles with branch/start ignored, done on the eighth
    vec("div_start", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, V_BUSY);
    idle("div_b1", V_BUSY);
    vec("div_b2_br", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, V_BUSY);
    vec("div_b3_st", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, V_BUSY);
    idle("div_b4", V_BUSY);
    idle("div_b5", V_BUSY);
    idle("div_b6", V_BUSY);
    vec("div_done_lu", 4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, V_DLU);
    idle("div_after", V_NORM);

    // Branch beats load-use and a mul/div start
    vec("br_lu", 4'd0, 4'd9, 1'b0, 1'b1, 4'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, V_BR);
    idle("br_after", V_NORM);
    vec("br_start", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, V_BR);
    idle("br_start_after", V_NORM);

    // Asynchronous reset in the middle of a divide
    vec("rdiv_start", 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, V_BUSY);
    idle("rdiv_busy", V_BUSY);
    vec("rdiv_rst", 4'd0, 4'd4, 1'b0, 1'b1, 4'd4, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, V_NORM);
    idle("rdiv_release", V_NORM);
    idle("rdiv_idle", V_NORM);

    // Saturation: 20 load-use stalls into a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      vec("sat_lu", 4'd0, 4'd6, 1'b0, 1'b1, 4'd6, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, V_LU);
    end
    idle("sat_hold", V_NORM);
    idle("sat_hold2", V_NORM);

    guard = 0;
    while ((sb.size() > 0) && (guard < 100)) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
